queue_arbiter: RTL
==================

QUEUE_ARBITER -- requirements
Module: queue_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one queue (2..8).
REQ-002 SHALL have parameter DEPTH, default 8, entry count of the downstream queue (power of 2).
REQ-003 SHALL have parameter DATA_W, default 4, payload width per entry.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port req_valid_i, input, NUM_REQ, per-requester push request.
REQ-007 SHALL have port req_data_i, input, NUM_REQ*DATA_W, payloads; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port req_ready_o, input-facing output, NUM_REQ, one-hot grant; at most one bit high.
REQ-009 SHALL have port q_push_o, output, 1, push strobe to the queue.
REQ-010 SHALL have port q_data_o, output, DATA_W, data to the queue.
REQ-011 SHALL have port q_pop_i, input, 1, consumer pop of the queue.
REQ-012 SHALL have port occ_o, output, $clog2(DEPTH)+1, tracked queue occupancy.
REQ-013 SHALL have ports full_o and empty_o, outputs, 1 each, occ_o==DEPTH and occ_o==0.

Function
REQ-014 SHALL transfer from requester i in the cycle req_valid_i[i] & req_ready_o[i] are both high.
REQ-015 SHALL compute req_ready_o combinationally from req_valid_i, round-robin pointer rr_q and occupancy; no grant when occ_o==DEPTH.
REQ-016 SHALL grant the first valid requester searching rr_q, rr_q+1, ... modulo NUM_REQ.
REQ-017 SHALL set rr_q to (granted index + 1) mod NUM_REQ after a transfer; rr_q SHALL hold when nothing is granted.
REQ-018 SHALL register the transfer: q_push_o high and q_data_o equal to the granted payload in the cycle after the transfer (latency 1); q_push_o low otherwise, q_data_o holds.
REQ-019 SHALL update occ_o next cycle: +1 on transfer without effective pop, -1 on effective pop without transfer, unchanged on both or neither.
REQ-020 SHALL treat q_pop_i as effective only when occ_o>0; pop at occ_o==0 is ignored.
REQ-021 SHALL count a transfer against occupancy in the transfer cycle, so in-flight pushes never overflow the queue.
REQ-022 SHALL permit a grant at occ_o==DEPTH-1 with a simultaneous pop, yielding occ_o==DEPTH-1.
REQ-023 SHALL keep a requester's req_valid_i/req_data_i stable until granted (requester obligation; not checked in RTL).

Reset
REQ-024 SHALL, with rst_i high at a clock edge, set rr_q=0, occ_o=0, q_push_o=0, q_data_o=0, and hold req_ready_o all-zero while rst_i is high.
REQ-025 SHALL discard any transfer in the reset cycle and any pending registered push; consumer queue SHALL be reset concurrently.

Configuration
REQ-026 SHALL, with macro QUEUE_ARBITER_PERF_CNT_EN defined, add output grant_cnt_o, NUM_REQ*16 bits: per-requester transfer counters, +1 per transfer, saturating at 16'hFFFF, cleared by rst_i.
REQ-027 SHALL, without QUEUE_ARBITER_PERF_CNT_EN, omit grant_cnt_o and all counter logic; all other behaviour identical.

Verification
REQ-028 SHALL cover: req_valid_i=4'b1111 held 8 cycles, no pop, rr_q=0 -> grants 0,1,2,3,0,1,2,3; occ_o reaches 8, full_o=1, req_ready_o=0 thereafter.
REQ-029 SHALL cover: req_valid_i=4'b0100, data 4'hA -> req_ready_o=4'b0100 same cycle; next cycle q_push_o=1, q_data_o=4'hA, occ_o=1.
REQ-030 SHALL cover: occ_o=8, q_pop_i=1 and req_valid_i[1]=1 same cycle -> no grant that cycle; next cycle occ_o=7 and requester 1 granted.
REQ-031 SHALL cover: occ_o=7, req_valid_i[0]=1 and q_pop_i=1 same cycle -> grant given, occ_o stays 7.
REQ-032 SHALL cover: occ_o=0, q_pop_i=1 -> occ_o stays 0, empty_o=1; then rst_i mid-burst with occ_o=5 -> occ_o=0, q_push_o=0 next cycle.
REQ-033 SHALL cover, with QUEUE_ARBITER_PERF_CNT_EN: 3 grants to requester 2 -> grant_cnt_o[2]=3, others 0; preloaded 16'hFFFF stays 16'hFFFF after another grant.

Source files
------------

// File: rtl/queue_arbiter.sv
// Round-robin arbiter feeding one shared queue with occupancy tracking and a registered push.
// Optional per-requester grant counters are enabled with QUEUE_ARBITER_PERF_CNT_EN.
module queue_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DEPTH   = 8,
   parameter int DATA_W  = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*DATA_W-1:0]     req_data_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   output logic                          q_push_o,
   output logic [DATA_W-1:0]             q_data_o,
   input  logic                          q_pop_i,
   output logic [$clog2(DEPTH):0]        occ_o,
   output logic                          full_o,
   output logic                          empty_o
`ifdef QUEUE_ARBITER_PERF_CNT_EN
   ,
   output logic [NUM_REQ*16-1:0]         grant_cnt_o
`endif
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int OCC_W = $clog2(DEPTH) + 1;
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

   logic [PTR_W-1:0] rr_q;
   logic [PTR_W-1:0] grant_idx;
   logic             transfer;
   logic             pop_eff;

   // Rotating index: base + offset wrapped into 0..NUM_REQ-1 (base is always < NUM_REQ).
   function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base, input int offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= NUM_REQ) begin
         sum = sum - NUM_REQ;
      end else begin
         sum = sum;
      end
      return PTR_W'(sum);
   endfunction

   assign full_o  = (occ_o == OCC_FULL);
   assign empty_o = (occ_o == OCC_W'(0));
   assign pop_eff = q_pop_i && !empty_o;

   // Grant search starting at rr_q; blocked in reset and when the queue is full.
   always_comb begin
      transfer  = 1'b0;
      grant_idx = rr_q;
      if (!rst_i && !full_o) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (!transfer && req_valid_i[rr_index(rr_q, k)]) begin
               transfer  = 1'b1;
               grant_idx = rr_index(rr_q, k);
            end else begin
               transfer  = transfer;
            end
         end
      end else begin
         transfer = 1'b0;
      end
      if (transfer) begin
         req_ready_o = NUM_REQ'(1'b1) << grant_idx;
      end else begin
         req_ready_o = '0;
      end
   end

   // Pointer, registered push and occupancy; a grant counts toward occupancy immediately.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q     <= '0;
         q_push_o <= 1'b0;
         q_data_o <= '0;
         occ_o    <= '0;
      end else begin
         q_push_o <= transfer;
         if (transfer) begin
            rr_q     <= rr_index(grant_idx, 1);
            q_data_o <= req_data_i[grant_idx*DATA_W +: DATA_W];
         end
         case ({transfer, pop_eff})
            2'b10:   occ_o <= occ_o + OCC_W'(1);
            2'b01:   occ_o <= occ_o - OCC_W'(1);
            default: occ_o <= occ_o;
         endcase
      end
   end

`ifdef QUEUE_ARBITER_PERF_CNT_EN
   // Saturating per-requester transfer counters.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         grant_cnt_o <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready_o[i] && (grant_cnt_o[i*16 +: 16] != 16'hFFFF)) begin
               grant_cnt_o[i*16 +: 16] <= grant_cnt_o[i*16 +: 16] + 16'd1;
            end
         end
      end
   end
`endif

endmodule
